// File: rtl/conv_frame_encoder.sv
// Streaming convolutional encoder: accepts data bits, appends K-1 zero tail bits,
// and presents one MSB-first packed coded frame over a valid/ready output.
module conv_frame_encoder #(
  parameter int MAX_CONSTRAINT_LENGTH = 9,
  parameter int MAX_CODE_RATE         = 3,
  parameter int DATA_FRAME_LENGTH     = 16,
  parameter int TRACEBACK_DEPTH       = 72
) (
  input  logic                                                sys_clk,
  input  logic                                                rst,
  input  logic                                                en,
  input  logic                                                i_code_rate,
  input  logic [1:0]                                          i_constr_len,
  input  logic [MAX_CODE_RATE-1:0][MAX_CONSTRAINT_LENGTH-1:0] i_gen_poly,
  input  logic                                                i_bit,
  input  logic                                                i_bit_valid,
  output logic                                                o_bit_ready,
  output logic [TRACEBACK_DEPTH-1:0]                          o_frame,
  output logic [7:0]                                          o_frame_len,
  output logic                                                o_frame_valid,
  input  logic                                                i_frame_ready,
  output logic                                                o_busy,
  output logic [1:0]                                          o_dbg_state
);

  localparam int KW  = MAX_CONSTRAINT_LENGTH;
  localparam int RW  = MAX_CODE_RATE;
  localparam int PW  = $clog2(TRACEBACK_DEPTH);
  localparam int CW  = $clog2(DATA_FRAME_LENGTH + 1);
  localparam int KLW = $clog2(KW + 1);

  // Handshakes: a bit transfers on a rising edge where i_bit_valid & o_bit_ready
  // (o_bit_ready already includes en); a frame transfers where o_frame_valid &
  // i_frame_ready & en. o_frame_valid never drops and o_frame never changes
  // until that frame transfer happens.
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, HOLD} state_t;

  state_t                  state, state_nxt;
  logic                    rate_q;
  logic [KLW-1:0]          k_q;
  logic [RW-1:0][KW-1:0]   poly_q;
  logic [KW-2:0]           hist_q;
  logic [CW-1:0]           cnt_q;
  logic [KLW-1:0]          flush_q;
  logic [PW-1:0]           ptr_q;
  logic [TRACEBACK_DEPTH-1:0] frame_q;
  logic [7:0]              len_q;

  logic                    is_idle, accept, step, eff_rate, cur_bit;
  logic [KLW-1:0]          k_in, eff_k;
  logic [RW-1:0][KW-1:0]   eff_poly;
  logic [KW-1:0]           win, mask;
  logic [PW-1:0]           base_ptr, ptr_nxt;
  logic [TRACEBACK_DEPTH-1:0] frame_nxt;
  logic [7:0]              len_base, len_nxt;

  // The first bit of a frame is encoded with the live configuration, since the
  // latched copy only becomes valid on the same edge.
  always_comb begin
    is_idle  = (state == IDLE);
    accept   = en & i_bit_valid & ((state == IDLE) | (state == LOAD));
    step     = accept | (en & (state == FLUSH));
    k_in     = KLW'(3) + KLW'({i_constr_len, 1'b0});
    eff_rate = is_idle ? i_code_rate : rate_q;
    eff_k    = is_idle ? k_in : k_q;
    eff_poly = is_idle ? i_gen_poly : poly_q;
    cur_bit  = (state == FLUSH) ? 1'b0 : i_bit;
    win      = {(is_idle ? {(KW-1){1'b0}} : hist_q), cur_bit};
    mask     = ~({KW{1'b1}} << eff_k);
    base_ptr = is_idle ? PW'(TRACEBACK_DEPTH - 1) : ptr_q;
    ptr_nxt  = base_ptr - (eff_rate ? PW'(3) : PW'(2));
    frame_nxt = is_idle ? '0 : frame_q;
    for (int j = 0; j < RW; j++) begin
      if (j < (eff_rate ? 3 : 2))
        frame_nxt[base_ptr - PW'(j)] = ^(win & eff_poly[j] & mask);
    end
    len_base = 8'(DATA_FRAME_LENGTH) + 8'(k_in) - 8'd1;
    len_nxt  = i_code_rate ? len_base * 8'd3 : len_base * 8'd2;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = LOAD;
      LOAD:  if (accept && cnt_q == CW'(DATA_FRAME_LENGTH - 1)) state_nxt = FLUSH;
      FLUSH: if (en && flush_q == k_q - KLW'(2)) state_nxt = HOLD;
      HOLD:  if (en && i_frame_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      rate_q  <= 1'b0;
      k_q     <= '0;
      poly_q  <= '0;
      hist_q  <= '0;
      cnt_q   <= '0;
      flush_q <= '0;
      ptr_q   <= '0;
      frame_q <= '0;
      len_q   <= '0;
    end else begin
      if (step) begin
        hist_q  <= win[KW-2:0];
        frame_q <= frame_nxt;
        ptr_q   <= ptr_nxt;
      end
      if (accept && is_idle) begin
        rate_q <= i_code_rate;
        k_q    <= k_in;
        poly_q <= i_gen_poly;
        len_q  <= len_nxt;
        cnt_q  <= CW'(1);
      end else if (accept) begin
        cnt_q  <= cnt_q + CW'(1);
      end
      if (state == LOAD && state_nxt == FLUSH) flush_q <= '0;
      else if (en && state == FLUSH)           flush_q <= flush_q + KLW'(1);
    end
  end

  assign o_bit_ready   = en & ((state == IDLE) | (state == LOAD));
  assign o_frame       = frame_q;
  assign o_frame_len   = len_q;
  assign o_frame_valid = (state == HOLD);
  assign o_busy        = (state != IDLE);
  assign o_dbg_state   = state;

endmodule
